// File: rtl/k_loop_controller.sv
// Kernel loop sequencer: delays a launch, then steps count_o over K cycles for n_rep iterations.
// All outputs registered; abort and reset return to IDLE without a done pulse.
module k_loop_controller #(
   parameter int START_DELAY = 5,
   parameter int K_W         = 8,
   parameter int REP_W       = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [K_W-1:0]   k_i,
   input  logic [REP_W-1:0] n_rep_i,
   output logic             start_d_o,
   output logic             iter_start_o,
   output logic [K_W-1:0]   count_o,
   output logic [REP_W-1:0] iter_o,
   output logic             busy_o,
   output logic             done_o
);

   typedef enum logic [1:0] {IDLE, DELAY, RUN, DONE} state_t;

   localparam logic [7:0] DLY_LAST   = 8'(START_DELAY - 1);
   localparam bit         NO_DELAY   = (START_DELAY == 1);
   localparam logic [K_W-1:0]   K_ONE = K_W'(1);
   localparam logic [REP_W-1:0] N_ONE = REP_W'(1);

   state_t           state;
   logic [K_W-1:0]   k_lat;
   logic [REP_W-1:0] n_lat;
   logic [7:0]       dly;
   logic [K_W-1:0]   k_last;
   logic [REP_W-1:0] n_last;

   // Latched values are nonzero whenever RUN is reachable, so these never underflow in use.
   assign k_last = k_lat - K_ONE;
   assign n_last = n_lat - N_ONE;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         k_lat        <= '0;
         n_lat        <= '0;
         dly          <= '0;
         start_d_o    <= 1'b0;
         iter_start_o <= 1'b0;
         count_o      <= '0;
         iter_o       <= '0;
         busy_o       <= 1'b0;
         done_o       <= 1'b0;
      end else begin
         start_d_o    <= 1'b0;
         iter_start_o <= 1'b0;
         done_o       <= 1'b0;
         case (state)
            IDLE: begin
               if (start_i && !abort_i) begin
                  k_lat <= k_i;
                  n_lat <= n_rep_i;
                  if (k_i == '0 || n_rep_i == '0) begin
                     state  <= DONE;
                     done_o <= 1'b1;
                  end else if (NO_DELAY) begin
                     state        <= RUN;
                     busy_o       <= 1'b1;
                     start_d_o    <= 1'b1;
                     iter_start_o <= 1'b1;
                     count_o      <= '0;
                     iter_o       <= '0;
                  end else begin
                     state  <= DELAY;
                     busy_o <= 1'b1;
                     dly    <= 8'd1;
                  end
               end
            end
            DELAY: begin
               if (abort_i) begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
                  dly    <= '0;
               end else if (dly == DLY_LAST) begin
                  state        <= RUN;
                  start_d_o    <= 1'b1;
                  iter_start_o <= 1'b1;
                  count_o      <= '0;
                  iter_o       <= '0;
                  dly          <= '0;
               end else begin
                  dly <= dly + 8'd1;
               end
            end
            RUN: begin
               if (abort_i) begin
                  state   <= IDLE;
                  busy_o  <= 1'b0;
                  count_o <= '0;
                  iter_o  <= '0;
               end else if (count_o == k_last) begin
                  count_o <= '0;
                  if (iter_o == n_last) begin
                     state  <= DONE;
                     busy_o <= 1'b0;
                     done_o <= 1'b1;
                     iter_o <= '0;
                  end else begin
                     iter_o       <= iter_o + N_ONE;
                     iter_start_o <= 1'b1;
                  end
               end else begin
                  count_o <= count_o + K_ONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state   <= IDLE;
               busy_o  <= 1'b0;
               count_o <= '0;
               iter_o  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_k_loop_controller.sv
// Randomised and directed stimulus against a timeline model of the loop controller.
module tb_k_loop_controller;

   localparam int SD = 5;
   localparam int KW = 4;
   localparam int RW = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [KW-1:0] k = '0;
   logic [RW-1:0] n = '0;
   logic          start_d, iter_start, busy, done;
   logic [KW-1:0] count;
   logic [RW-1:0] iter;

   typedef struct packed {
      logic          start_d;
      logic          iter_start;
      logic [KW-1:0] count;
      logic [RW-1:0] iter;
      logic          busy;
      logic          done;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   failures = 0;

   // Model: a launch is described by the cycle number t since the accepting edge.
   bit m_active = 1'b0;
   int m_t = 0;
   int m_k = 0;
   int m_n = 0;

   always #5 clk = ~clk;

   k_loop_controller #(.START_DELAY(SD), .K_W(KW), .REP_W(RW)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort),
      .k_i(k), .n_rep_i(n),
      .start_d_o(start_d), .iter_start_o(iter_start), .count_o(count),
      .iter_o(iter), .busy_o(busy), .done_o(done)
   );

   function automatic bit model_in_done();
      int run_len = m_k * m_n;
      if (!m_active) return 1'b0;
      if (run_len == 0) return (m_t == 1);
      return (m_t == SD + run_len);
   endfunction

   function automatic obs_t model_out();
      obs_t o = '0;
      int run_len = m_k * m_n;
      int r;
      if (!m_active) return o;
      if (model_in_done()) begin
         o.done = 1'b1;
         return o;
      end
      o.busy = 1'b1;
      if (m_t >= SD) begin
         r = m_t - SD;
         o.start_d    = (r == 0);
         o.count      = KW'(r % m_k);
         o.iter       = RW'(r / m_k);
         o.iter_start = ((r % m_k) == 0);
      end
      return o;
   endfunction

   task automatic step(input bit r, input bit s, input bit a, input int kv, input int nv);
      @(negedge clk);
      rst   = r;
      start = s;
      abort = a;
      k     = kv[KW-1:0];
      n     = nv[RW-1:0];
      if (r) begin
         m_active = 1'b0;
      end else if (m_active) begin
         if (model_in_done() || a) m_active = 1'b0;
         else m_t++;
      end else if (s && !a) begin
         m_active = 1'b1;
         m_t = 1;
         m_k = kv % (1 << KW);
         m_n = nv % (1 << RW);
      end
      exp_q.push_back(model_out());
   endtask

   task automatic idle(input int cycles);
      for (int i = 0; i < cycles; i++)
         step(1'b0, 1'b0, 1'b0, int'($urandom_range(15)), int'($urandom_range(7)));
   endtask

   task automatic launch(input int kv, input int nv);
      step(1'b0, 1'b1, 1'b0, kv, nv);
   endtask

   initial begin : monitor
      obs_t e;
      obs_t got;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = '{start_d, iter_start, count, iter, busy, done};
            checks++;
            if (got !== e) begin
               failures++;
               $display("FAIL outputs @%0t got sd=%b is=%b cnt=%0d it=%0d busy=%b done=%b required sd=%b is=%b cnt=%0d it=%0d busy=%b done=%b",
                        $time, got.start_d, got.iter_start, got.count, got.iter, got.busy, got.done,
                        e.start_d, e.iter_start, e.count, e.iter, e.busy, e.done);
            end
         end
      end
   end

   initial begin : stimulus
      repeat (3) step(1'b1, 1'b0, 1'b0, 0, 0);
      // Reset deasserting on the same edge as a start: accepted at once.
      launch(3, 2);           idle(13);
      launch(0, 4);           idle(4);
      launch(2, 0);           idle(3);
      // Abort mid-run, then relaunch two cycles later.
      launch(4, 3);           idle(7);
      step(1'b0, 1'b0, 1'b1, 0, 0);
      idle(1);
      launch(4, 3);           idle(20);
      // Re-pulsed starts with different operands are ignored.
      launch(2, 2);           idle(2);
      launch(7, 7);           idle(3);
      launch(9, 5);           idle(6);
      // Reset mid-run, start on the first edge after reset.
      launch(5, 5);           idle(6);
      step(1'b1, 1'b0, 1'b0, 0, 0);
      launch(1, 1);           idle(8);
      // Maximum K and n_rep wrap without carry.
      launch(15, 7);          idle(SD + 15 * 7 + 3);
      // Start presented during the DONE cycle is ignored.
      launch(1, 1);           idle(5);
      launch(3, 3);           idle(8);
      // Abort beats start in IDLE.
      step(1'b0, 1'b1, 1'b1, 3, 1);
      idle(8);
      // Abort on the final RUN cycle suppresses done.
      launch(2, 1);           idle(5);
      step(1'b0, 1'b0, 1'b1, 0, 0);
      idle(3);
      // Abort during DELAY.
      launch(3, 1);           idle(2);
      step(1'b0, 1'b0, 1'b1, 0, 0);
      idle(8);
      for (int i = 0; i < 5000; i++) begin
         bit r = ($urandom_range(199) == 0);
         bit s = ($urandom_range(5) == 0);
         bit a = ($urandom_range(39) == 0);
         int kv = ($urandom_range(7) == 0) ? 15 : int'($urandom_range(5));
         int nv = int'($urandom_range(7));
         step(r, s, a, kv, nv);
      end
      idle(4);
      @(posedge clk);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
